ahb_slave_arbiter: RTL and testbench
====================================

// Module: ahb_slave_arbiter
// PURPOSE
//  Per-slave arbiter of the AHB interconnect, directly downstream of the per-master address decoders.
//  Collects the hreq bit for this slave from every master decoder and grants one master at a time.
//  Holds the grant across bursts and locked sequences, and changes owner only on hready.
//  Exports address-phase and data-phase master indices that steer the slave-side address and write-data muxes.
// PARAMETERS
//  MASTER_NUM    4   number of masters that can address this slave (>=2)
//  MIDX_W        $clog2(MASTER_NUM)   width of master index outputs
// PORTS
//  hclk          in   1               bus clock, all state on rising edge
//  hreset        in   1               asynchronous, active-high reset
//  hreq          in   MASTER_NUM      bit i = decoder of master i requests this slave (already IDLE-gated)
//  htrans        in   MASTER_NUM x htrans_type  current htrans of each master (IDLE/BUSY/NONSEQ/SEQ)
//  hlock         in   MASTER_NUM      hmastlock of each master
//  hready        in   1               hready of this slave (transfer completes / bus advances)
//  hgrant        out  MASTER_NUM      one-hot grant, registered; all-zero = no owner
//  hmaster_addr  out  MIDX_W          index of current owner (address phase)
//  hsel          out  1               slave select for address phase = owner valid && hreq[owner]
//  hmaster_data  out  MIDX_W          index of master owning the data phase, registered
//  data_valid    out  1               data phase in progress for hmaster_data
// BEHAVIOUR
//  Reset (async, any time incl. mid-burst): hgrant=0, hmaster_addr=0, hmaster_data=0,
//   data_valid=0, rr_ptr=MASTER_NUM-1; hsel=0 follows because owner invalid.
//  State: own_valid, own_idx, rr_ptr (last granted index). Two states: NO_OWNER, OWNED.
//  All state updates only on rising edge with hready=1; with hready=0 everything is held
//   regardless of hreq/htrans/hlock changes.
//  hold = own_valid && (hlock[own_idx] || (hreq[own_idx] && htrans[own_idx] in {BUSY,SEQ})).
//  On hready=1 edge:
//   - hold=1 -> owner unchanged (burst / locked sequence not interruptible; lock holds even through IDLE).
//   - hold=0 and |hreq -> new owner = first i with hreq[i], searching rr_ptr+1, rr_ptr+2, ...
//     mod MASTER_NUM; own_valid<=1, rr_ptr<=i. The current owner issuing a new NONSEQ competes
//     normally and is re-granted only if no other requester precedes it in this order.
//   - hold=0 and hreq==0 -> NO_OWNER (hgrant=0); rr_ptr unchanged.
//   - data_valid<=hsel; hmaster_data<=hmaster_addr (when hsel=1, else hold last value).
//  hgrant = one-hot(own_idx) when own_valid, else 0. hmaster_addr = own_idx.
//  Latency: request at edge N (hready=1, no hold) -> hgrant visible after edge N
//   -> data phase (data_valid) after next hready edge. Master-side stages hold the address until granted.
//  Round-robin wraps from MASTER_NUM-1 to 0. Simultaneous requests are resolved only by the rr order.
//  hgrant is always one-hot or zero, never multi-hot. Indices are unsigned MIDX_W arithmetic, mod MASTER_NUM.
// TESTING
//  T1 reset: assert hreset mid-traffic -> hgrant=0,hsel=0,data_valid=0,hmaster_data=0 immediately (async).
//  T2 single: hreq=4'b0100,htrans[2]=NONSEQ,hready=1 -> next edge hgrant=4'b0100,hmaster_addr=2,hsel=1;
//     following edge data_valid=1,hmaster_data=2.
//  T3 fairness: from reset hreq=4'b1111, every master NONSEQ each cycle, hready=1 -> grants 0,1,2,3,0.
//  T4 burst hold: master1 owner with htrans=SEQ, hreq=4'b0011 -> hgrant stays 4'b0010 until htrans[1]=NONSEQ,
//     then hgrant=4'b0001.
//  T5 stall: owner 0, hready=0 for 3 cycles while hreq=4'b1000 only -> hgrant stays 4'b0001;
//     first hready=1 edge -> 4'b1000.
//  T6 lock: hlock[3]=1, htrans[3]=IDLE, hreq=4'b0001 -> hgrant stays 4'b1000 until hlock[3]=0.

Source files
------------

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin grant among master decoders, held across
// bursts and locked sequences, with address- and data-phase master indices.
module ahb_slave_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic [MASTER_NUM-1:0]      hreq,
  input  logic [MASTER_NUM-1:0][1:0] htrans,
  input  logic [MASTER_NUM-1:0]      hlock,
  input  logic                       hready,
  output logic [MASTER_NUM-1:0]      hgrant,
  output logic [MIDX_W-1:0]          hmaster_addr,
  output logic                       hsel,
  output logic [MIDX_W-1:0]          hmaster_data,
  output logic                       data_valid
);

  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  typedef enum logic [0:0] {
    NO_OWNER = 1'b0,
    OWNED    = 1'b1
  } arb_state_t;

  arb_state_t                state_r, state_nx_s;
  logic [MIDX_W-1:0]         own_idx_r, own_idx_nx_s;
  logic [MIDX_W-1:0]         rr_ptr_r, rr_ptr_nx_s;
  logic [MIDX_W-1:0]         hmaster_data_r, hmaster_data_nx_s;
  logic                      data_valid_r, data_valid_nx_s;
  logic [MASTER_NUM-1:0]     hgrant_r;
  logic                      own_valid_s;
  logic                      hold_s;
  logic                      hsel_s;
  logic [MIDX_W:0]           pick_s;

  // Returns {found, index} of the first requester after ptr in wrapping order.
  function automatic logic [MIDX_W:0] rr_pick(input logic [MASTER_NUM-1:0] req,
                                              input logic [MIDX_W-1:0]     ptr);
    logic [MIDX_W:0] res;
    logic            found;
    int              c;
    res   = {(MIDX_W+1){1'b0}};
    found = 1'b0;
    for (int k = 1; k <= MASTER_NUM; k++) begin
      c = int'(ptr) + k;
      if (c >= MASTER_NUM) begin
        c = c - MASTER_NUM;
      end else begin
        c = c;
      end
      if (!found && req[MIDX_W'(c)]) begin
        found = 1'b1;
        res   = {1'b1, MIDX_W'(c)};
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  function automatic logic [MASTER_NUM-1:0] to_onehot(input logic [MIDX_W-1:0] idx);
    logic [MASTER_NUM-1:0] v;
    v      = {MASTER_NUM{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  assign own_valid_s = (state_r == OWNED);
  assign hsel_s      = own_valid_s && hreq[own_idx_r];
  assign pick_s      = rr_pick(hreq, rr_ptr_r);
  // A lock keeps ownership even through IDLE; a burst only while it keeps requesting.
  assign hold_s      = own_valid_s &&
                       (hlock[own_idx_r] ||
                        (hreq[own_idx_r] && ((htrans[own_idx_r] == HTRANS_BUSY) ||
                                             (htrans[own_idx_r] == HTRANS_SEQ))));

  // Next-state logic: nothing moves unless the slave signals hready.
  always_comb begin
    state_nx_s        = state_r;
    own_idx_nx_s      = own_idx_r;
    rr_ptr_nx_s       = rr_ptr_r;
    data_valid_nx_s   = data_valid_r;
    hmaster_data_nx_s = hmaster_data_r;
    if (hready) begin
      data_valid_nx_s = hsel_s;
      if (hsel_s) begin
        hmaster_data_nx_s = own_idx_r;
      end else begin
        hmaster_data_nx_s = hmaster_data_r;
      end
      case (state_r)
        OWNED, NO_OWNER: begin
          if (hold_s) begin
            state_nx_s = OWNED;
          end else if (pick_s[MIDX_W]) begin
            state_nx_s   = OWNED;
            own_idx_nx_s = pick_s[MIDX_W-1:0];
            rr_ptr_nx_s  = pick_s[MIDX_W-1:0];
          end else begin
            state_nx_s = NO_OWNER;
          end
        end
        default: begin
          state_nx_s = NO_OWNER;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_r        <= NO_OWNER;
      own_idx_r      <= {MIDX_W{1'b0}};
      rr_ptr_r       <= MIDX_W'(MASTER_NUM - 1);
      data_valid_r   <= 1'b0;
      hmaster_data_r <= {MIDX_W{1'b0}};
      hgrant_r       <= {MASTER_NUM{1'b0}};
    end else begin
      state_r        <= state_nx_s;
      own_idx_r      <= own_idx_nx_s;
      rr_ptr_r       <= rr_ptr_nx_s;
      data_valid_r   <= data_valid_nx_s;
      hmaster_data_r <= hmaster_data_nx_s;
      hgrant_r       <= (state_nx_s == OWNED) ? to_onehot(own_idx_nx_s) : {MASTER_NUM{1'b0}};
    end
  end

  assign hgrant       = hgrant_r;
  assign hmaster_addr = own_idx_r;
  assign hsel         = hsel_s;
  assign hmaster_data = hmaster_data_r;
  assign data_valid   = data_valid_r;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Self-checking bench for ahb_slave_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural round-robin ownership model.
module tb_ahb_slave_arbiter;

  localparam int N = 4;
  localparam int W = 2;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic              hclk;
  logic              hreset;
  logic [N-1:0]      hreq;
  logic [N-1:0][1:0] htrans;
  logic [N-1:0]      hlock;
  logic              hready;
  logic [N-1:0]      hgrant;
  logic [W-1:0]      hmaster_addr;
  logic              hsel;
  logic [W-1:0]      hmaster_data;
  logic              data_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_valid;
  int m_idx;
  int m_rr;
  bit m_dv;
  int m_hmd;

  ahb_slave_arbiter #(.MASTER_NUM(N), .MIDX_W(W)) dut (
    .hclk(hclk), .hreset(hreset), .hreq(hreq), .htrans(htrans), .hlock(hlock),
    .hready(hready), .hgrant(hgrant), .hmaster_addr(hmaster_addr), .hsel(hsel),
    .hmaster_data(hmaster_data), .data_valid(data_valid)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic bit model_hsel();
    return m_valid && hreq[m_idx];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_idx = 0; m_rr = N - 1; m_dv = 1'b0; m_hmd = 0;
  endtask

  task automatic model_step();
    bit hold, sel;
    if (hready) begin
      sel  = model_hsel();
      hold = m_valid && (hlock[m_idx] ||
             (hreq[m_idx] && (htrans[m_idx] == BUSY || htrans[m_idx] == SEQ)));
      if (sel) m_hmd = m_idx;
      m_dv = sel;
      if (!hold) begin
        if (hreq == '0) m_valid = 1'b0;
        else begin
          for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (hreq[i]) begin
              m_idx = i; m_rr = i; m_valid = 1'b1;
              break;
            end
          end
        end
      end
    end
  endtask

  // One bus cycle: advance the model, pass the edge, settle.
  task automatic tick();
    model_step();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    hreq = '0; hlock = '0; hready = 1'b1;
    for (int i = 0; i < N; i++) htrans[i] = IDLE;
  endtask

  task automatic apply_reset();
    idle_inputs();
    hreset = 1'b1;
    model_reset();
    @(posedge hclk);
    #1;
    hreset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (hgrant !== 4'b0000 || hsel !== 1'b0 || data_valid !== 1'b0 || hmaster_data !== 2'd0 || hmaster_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got grant=%b sel=%b dv=%b hmd=%0d hma=%0d required all zero",
               hgrant, hsel, data_valid, hmaster_data, hmaster_addr);
    end
    // Build up traffic, then reset asynchronously between edges
    hreq = 4'b1110; htrans = {NONSEQ, NONSEQ, NONSEQ, IDLE};
    repeat (3) tick();
    #2 hreset = 1'b1;
    #1;
    n_checks++;
    if (hgrant !== 4'b0000 || hsel !== 1'b0 || data_valid !== 1'b0 || hmaster_data !== 2'd0 || hmaster_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async: got grant=%b sel=%b dv=%b hmd=%0d hma=%0d required all zero",
               hgrant, hsel, data_valid, hmaster_data, hmaster_addr);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    hreq = 4'b0100; htrans[2] = NONSEQ;
    tick();
    n_checks++;
    if (hgrant !== 4'b0100 || hmaster_addr !== 2'd2 || hsel !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%b hma=%0d sel=%b required 0100 2 1", hgrant, hmaster_addr, hsel);
    end
    tick();
    n_checks++;
    if (data_valid !== 1'b1 || hmaster_data !== 2'd2) begin
      n_fail++;
      $display("FAIL single_data: got dv=%b hmd=%0d required 1 2", data_valid, hmaster_data);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    hreq = 4'b1111;
    for (int i = 0; i < N; i++) htrans[i] = NONSEQ;
    for (int s = 0; s < 5; s++) begin
      tick();
      n_checks++;
      if (hgrant !== exp_seq[s]) begin
        n_fail++;
        $display("FAIL fairness_%0d: got %b required %b", s, hgrant, exp_seq[s]);
      end
    end
  endtask

  task automatic test_burst_hold();
    apply_reset();
    hreq = 4'b0010; htrans[1] = NONSEQ;
    tick();
    hreq = 4'b0011; htrans[1] = SEQ; htrans[0] = NONSEQ;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_checks++;
      if (hgrant !== 4'b0010) begin
        n_fail++;
        $display("FAIL burst_hold_%0d: got %b required 0010", s, hgrant);
      end
    end
    htrans[1] = NONSEQ;
    tick();
    n_checks++;
    if (hgrant !== 4'b0001) begin
      n_fail++;
      $display("FAIL burst_release: got %b required 0001", hgrant);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    hreq = 4'b0001; htrans[0] = NONSEQ;
    tick();
    hready = 1'b0; hreq = 4'b1000; htrans[0] = IDLE; htrans[3] = NONSEQ;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_checks++;
      if (hgrant !== 4'b0001 || data_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%0d: got grant=%b dv=%b required 0001 0", s, hgrant, data_valid);
      end
    end
    hready = 1'b1;
    tick();
    n_checks++;
    if (hgrant !== 4'b1000) begin
      n_fail++;
      $display("FAIL stall_release: got %b required 1000", hgrant);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    hreq = 4'b1000; htrans[3] = NONSEQ;
    tick();
    hlock[3] = 1'b1; htrans[3] = IDLE; hreq = 4'b0001; htrans[0] = NONSEQ;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_checks++;
      if (hgrant !== 4'b1000) begin
        n_fail++;
        $display("FAIL lock_hold_%0d: got %b required 1000", s, hgrant);
      end
    end
    hlock[3] = 1'b0;
    tick();
    n_checks++;
    if (hgrant !== 4'b0001) begin
      n_fail++;
      $display("FAIL lock_release: got %b required 0001", hgrant);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_g;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      hreq   = N'($urandom_range(0, 15));
      hready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        htrans[i] = 2'($urandom_range(0, 3));
        hlock[i]  = ($urandom_range(0, 15) == 0);
      end
      tick();
      exp_g = m_valid ? (N'(1) << m_idx) : '0;
      n_checks++;
      if (hgrant !== exp_g) begin
        n_fail++;
        $display("FAIL rand_grant c=%0d: got %b required %b", c, hgrant, exp_g);
      end
      n_checks++;
      if (hmaster_addr !== W'(m_idx)) begin
        n_fail++;
        $display("FAIL rand_hmaster_addr c=%0d: got %0d required %0d", c, hmaster_addr, m_idx);
      end
      n_checks++;
      if (hsel !== model_hsel()) begin
        n_fail++;
        $display("FAIL rand_hsel c=%0d: got %b required %b", c, hsel, model_hsel());
      end
      n_checks++;
      if (data_valid !== m_dv || hmaster_data !== W'(m_hmd)) begin
        n_fail++;
        $display("FAIL rand_data c=%0d: got dv=%b hmd=%0d required %b %0d",
                 c, data_valid, hmaster_data, m_dv, m_hmd);
      end
    end
  endtask

  initial begin
    hreset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_burst_hold();
    test_stall();
    test_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
